// File: rtl/mmu_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg
// Shared MMU definitions for the TLB refill walker:
//   - walker FSM state encodings and state enum
//   - PTE bit positions (PFN_LSB, D_BIT, V_BIT)
//   - TLB entry field offsets for entry layout {VPN, ASID, PFN, D, V}
//   - default widths for the walker parameters
//   - helper that forms the PTE address from the table base and a VPN
// -----------------------------------------------------------------------------
package mmu_pkg;

    // Default widths.
    localparam int DEF_LOG_WAYS = 2;
    localparam int DEF_VPN_W    = 22;
    localparam int DEF_PFN_W    = 22;
    localparam int ASID_W       = 8;

    // PTE word layout: PFN in [31:PFN_LSB], dirty and valid in the low bits.
    localparam int PFN_LSB = 10;
    localparam int D_BIT   = 1;
    localparam int V_BIT   = 0;

    // TLB entry layout, LSB first: V, D, PFN, ASID, VPN.
    localparam int ENT_V_BIT   = 0;
    localparam int ENT_D_BIT   = 1;
    localparam int ENT_PFN_LSB = 2;

    function automatic int ent_asid_lsb(input int pfn_w);
        return ENT_PFN_LSB + pfn_w;
    endfunction

    function automatic int ent_vpn_lsb(input int pfn_w);
        return ENT_PFN_LSB + pfn_w + ASID_W;
    endfunction

    // Walker FSM state encodings, kept as plain constants so legacy code
    // comparing raw state bits still lines up with the enum below.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_REQ   = S_REQ,
        ST_WRITE = S_WRITE,
        ST_RESP  = S_RESP
    } walk_state_e;

    // PTE address: base + VPN * 4, wrapping modulo 2^32.
    function automatic logic [31:0] pte_addr(input logic [31:0] base,
                                             input logic [31:0] vpn_ext);
        return base + {vpn_ext[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/tlb_refill_walker_if.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker_if
// PTE read bus between the refill walker and the memory system.
//   MEM_REQ    walker -> memory   read request, held until MEM_ACK
//   MEM_ADDR   walker -> memory   PTE physical address, stable while MEM_REQ
//   MEM_ACK    memory -> walker   read complete, MEM_RDATA valid this cycle
//   MEM_RDATA  memory -> walker   PTE word
// Modports: master (walker side), slave (memory side).
// -----------------------------------------------------------------------------
interface tlb_refill_walker_if;

    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;

    modport master (
        output MEM_REQ,
        output MEM_ADDR,
        input  MEM_ACK,
        input  MEM_RDATA
    );

    modport slave (
        input  MEM_REQ,
        input  MEM_ADDR,
        output MEM_ACK,
        output MEM_RDATA
    );

endinterface

// File: rtl/tlb_victim_ctr.sv
// -----------------------------------------------------------------------------
// tlb_victim_ctr
// Round-robin victim pointer for TLB refills.
//   CLK    in   clock
//   RESET  in   synchronous active-high reset, clears IDX
//   INC    in   advance to the next entry (one TLB write happened)
//   IDX    out  current victim entry, wraps from 2^LOG_WAYS-1 to 0
// -----------------------------------------------------------------------------
module tlb_victim_ctr #(
    parameter int LOG_WAYS = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INC,
    output logic [LOG_WAYS-1:0] IDX
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            IDX <= '0;
        end else if (INC) begin
            IDX <= IDX + LOG_WAYS'(1);
        end
    end

endmodule

// File: rtl/tlb_refill_walker.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker
// Hardware TLB refill engine. Accepts one miss at a time (data side has
// priority), reads the single-level PTE at PT_BASE + VPN*4, writes a TLB
// entry when the PTE is valid, then pulses DONE or FAULT to the requester.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   PT_BASE               page-table base, sampled when a miss is accepted
//   ASID                  address-space ID, sampled when a miss is accepted
//   I_MISS / I_VPN        ifetch miss (level) and its VPN
//   D_MISS / D_VPN        data miss (level) and its VPN
//   mem                   PTE read bus (MEM_REQ/MEM_ADDR/MEM_ACK/MEM_RDATA)
//   TLB_WE                one-cycle TLB write strobe
//   TLB_INDEX             victim entry for the write
//   TLB_ENTRY             {VPN, ASID, PFN, D, V}, MSB first
//   I_DONE / D_DONE       refill complete pulses
//   I_FAULT / D_FAULT     invalid-PTE pulses
//   BUSY                  walk in progress
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module tlb_refill_walker
    import mmu_pkg::*;
#(
    parameter int LOG_WAYS = DEF_LOG_WAYS,
    parameter int VPN_W    = DEF_VPN_W,
    parameter int PFN_W    = DEF_PFN_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [31:0]               PT_BASE,
    input  logic [7:0]                ASID,
    input  logic                      I_MISS,
    input  logic [VPN_W-1:0]          I_VPN,
    input  logic                      D_MISS,
    input  logic [VPN_W-1:0]          D_VPN,
    tlb_refill_walker_if.master       mem,
    output logic                      TLB_WE,
    output logic [LOG_WAYS-1:0]       TLB_INDEX,
    output logic [VPN_W+PFN_W+9:0]    TLB_ENTRY,
    output logic                      I_DONE,
    output logic                      D_DONE,
    output logic                      I_FAULT,
    output logic                      D_FAULT,
    output logic                      BUSY
);

    walk_state_e state;

    logic              src_d;     // 1: walk serves the data side
    logic              fault_q;   // fetched PTE was invalid
    logic [VPN_W-1:0]  vpn_q;
    logic [7:0]        asid_q;
    logic [31:0]       addr_q;
    logic [PFN_W-1:0]  pfn_q;
    logic              d_q;
    logic              v_q;

    // Miss arbitration in IDLE: data always wins over ifetch.
    logic              accept;
    logic              accept_d;
    logic [VPN_W-1:0]  accept_vpn;
    logic [31:0]       accept_addr;

    always_comb begin
        accept      = D_MISS | I_MISS;
        accept_d    = D_MISS;
        accept_vpn  = D_MISS ? D_VPN : I_VPN;
        accept_addr = pte_addr(PT_BASE, 32'(accept_vpn));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            src_d   <= 1'b0;
            fault_q <= 1'b0;
            vpn_q   <= '0;
            asid_q  <= '0;
            addr_q  <= '0;
            pfn_q   <= '0;
            d_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_d   <= accept_d;
                        vpn_q   <= accept_vpn;
                        asid_q  <= ASID;
                        addr_q  <= accept_addr;
                        fault_q <= 1'b0;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem.MEM_ACK) begin
                        pfn_q   <= mem.MEM_RDATA[PFN_LSB +: PFN_W];
                        d_q     <= mem.MEM_RDATA[D_BIT];
                        v_q     <= mem.MEM_RDATA[V_BIT];
                        fault_q <= ~mem.MEM_RDATA[V_BIT];
                        state   <= mem.MEM_RDATA[V_BIT] ? ST_WRITE : ST_RESP;
                    end
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // Always return through IDLE so the requester gets one
                    // lookup cycle against the freshly written entry.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tlb_victim_ctr #(
        .LOG_WAYS (LOG_WAYS)
    ) u_victim (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (TLB_WE),
        .IDX   (TLB_INDEX)
    );

    // State decodes and registered data outputs.
    assign mem.MEM_REQ  = (state == ST_REQ);
    assign mem.MEM_ADDR = addr_q;
    assign TLB_WE       = (state == ST_WRITE);
    assign BUSY         = (state != ST_IDLE);
    assign D_DONE       = (state == ST_RESP) &  src_d & ~fault_q;
    assign I_DONE       = (state == ST_RESP) & ~src_d & ~fault_q;
    assign D_FAULT      = (state == ST_RESP) &  src_d &  fault_q;
    assign I_FAULT      = (state == ST_RESP) & ~src_d &  fault_q;
    assign TLB_ENTRY    = {vpn_q, asid_q, pfn_q, d_q, v_q};

endmodule

// File: tb/tb_tlb_refill_walker.sv
module tb_tlb_refill_walker;

    localparam int LOG_WAYS = 2;
    localparam int VPN_W    = 22;
    localparam int PFN_W    = 22;
    localparam int WAYS     = 1 << LOG_WAYS;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [31:0]             PT_BASE;
    logic [7:0]              ASID;
    logic                    I_MISS;
    logic [VPN_W-1:0]        I_VPN;
    logic                    D_MISS;
    logic [VPN_W-1:0]        D_VPN;
    logic                    TLB_WE;
    logic [LOG_WAYS-1:0]     TLB_INDEX;
    logic [VPN_W+PFN_W+9:0]  TLB_ENTRY;
    logic                    I_DONE, D_DONE, I_FAULT, D_FAULT, BUSY;
    logic [3:0]              pulses;

    int tests = 0;
    int fails = 0;
    int unsigned model_ctr = 0;
    logic [31:0] last_addr;
    logic [53:0] last_entry;

    tlb_refill_walker_if mem_bus ();

    tlb_refill_walker #(
        .LOG_WAYS (LOG_WAYS),
        .VPN_W    (VPN_W),
        .PFN_W    (PFN_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PT_BASE   (PT_BASE),
        .ASID      (ASID),
        .I_MISS    (I_MISS),
        .I_VPN     (I_VPN),
        .D_MISS    (D_MISS),
        .D_VPN     (D_VPN),
        .mem       (mem_bus),
        .TLB_WE    (TLB_WE),
        .TLB_INDEX (TLB_INDEX),
        .TLB_ENTRY (TLB_ENTRY),
        .I_DONE    (I_DONE),
        .D_DONE    (D_DONE),
        .I_FAULT   (I_FAULT),
        .D_FAULT   (D_FAULT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    assign pulses = {I_DONE, D_DONE, I_FAULT, D_FAULT};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete walk, started at a negedge with the walker idle.
    // Expected values come from the address/entry rules, not the RTL.
    task automatic walk(input bit src_d, input logic [21:0] vpn, input logic [7:0] asid,
                        input logic [31:0] base, input logic [31:0] pte,
                        input int unsigned delay, input bit flush);
        logic [31:0] e_addr;
        logic [53:0] e_ent;
        logic [3:0]  e_pulse;
        e_addr = base + 32'(vpn) * 32'd4;
        e_ent  = (54'(vpn) << 32) | (54'(asid) << 24) | (54'(pte >> 10) << 2) | 54'(pte & 32'd3);
        if (pte[0]) e_pulse = src_d ? 4'b0100 : 4'b1000;
        else        e_pulse = src_d ? 4'b0001 : 4'b0010;

        if (src_d) begin D_MISS = 1'b1; D_VPN = vpn; end
        else       begin I_MISS = 1'b1; I_VPN = vpn; end
        ASID    = asid;
        PT_BASE = base;

        @(negedge CLK);
        check("req_rise", 64'(mem_bus.MEM_REQ), 64'd1);
        check("busy", 64'(BUSY), 64'd1);
        check("mem_addr", 64'(mem_bus.MEM_ADDR), 64'(e_addr));
        last_addr = mem_bus.MEM_ADDR;
        // Base and ASID must have been captured at accept time.
        PT_BASE = $urandom();
        ASID    = 8'($urandom());
        if (flush) begin
            if (src_d) D_MISS = 1'b0; else I_MISS = 1'b0;
        end

        for (int unsigned i = 0; i < delay; i++) begin
            @(negedge CLK);
            check("req_hold", 64'(mem_bus.MEM_REQ), 64'd1);
            check("addr_hold", 64'(mem_bus.MEM_ADDR), 64'(e_addr));
            check("we_wait", 64'(TLB_WE), 64'd0);
        end

        mem_bus.MEM_ACK   = 1'b1;
        mem_bus.MEM_RDATA = pte;
        @(negedge CLK);
        mem_bus.MEM_ACK   = 1'b0;
        mem_bus.MEM_RDATA = $urandom();
        check("req_fall", 64'(mem_bus.MEM_REQ), 64'd0);

        if (pte[0]) begin
            check("we", 64'(TLB_WE), 64'd1);
            check("index", 64'(TLB_INDEX), 64'(model_ctr));
            check("entry", 64'(TLB_ENTRY), 64'(e_ent));
            check("pulse_early", 64'(pulses), 64'd0);
            last_entry = TLB_ENTRY;
            model_ctr  = (model_ctr + 1) % WAYS;
            @(negedge CLK);
        end

        check("pulse", 64'(pulses), 64'(e_pulse));
        check("we_resp", 64'(TLB_WE), 64'd0);
        if (src_d) D_MISS = 1'b0; else I_MISS = 1'b0;

        @(negedge CLK);
        check("idle_busy", 64'(BUSY), 64'd0);
        check("idle_req", 64'(mem_bus.MEM_REQ), 64'd0);
        check("idle_pulse", 64'(pulses), 64'd0);
        check("idx_keep", 64'(TLB_INDEX), 64'(model_ctr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pte_r;
        RESET = 1'b1;
        PT_BASE = '0; ASID = '0;
        I_MISS = 1'b0; I_VPN = '0; D_MISS = 1'b0; D_VPN = '0;
        mem_bus.MEM_ACK = 1'b0; mem_bus.MEM_RDATA = '0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_req", 64'(mem_bus.MEM_REQ), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_we", 64'(TLB_WE), 64'd0);
        check("rst_index", 64'(TLB_INDEX), 64'd0);
        check("rst_entry", 64'(TLB_ENTRY), 64'd0);
        check("rst_addr", 64'(mem_bus.MEM_ADDR), 64'd0);
        check("rst_pulse", 64'(pulses), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // ACK while idle is ignored
        mem_bus.MEM_ACK = 1'b1; mem_bus.MEM_RDATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        mem_bus.MEM_ACK = 1'b0;
        check("stray_ack_busy", 64'(BUSY), 64'd0);
        check("stray_ack_we", 64'(TLB_WE), 64'd0);
        @(negedge CLK);
        check("stray_ack_pulse", 64'(pulses), 64'd0);

        // Data refill example
        walk(1'b1, 22'h3, 8'h5A, 32'h0010_0000, 32'h1234_5403, 2, 1'b0);
        check("ex_addr", 64'(last_addr), 64'h0010_000C);
        check("ex_pfn", 64'(last_entry[23:2]), 64'h048D15);
        check("ex_dv", 64'(last_entry[1:0]), 64'd3);

        // Fault: no write, counter stays
        walk(1'b1, 22'h3, 8'h5A, 32'h0010_0000, 32'h0000_0000, 2, 1'b0);
        check("fault_idx", 64'(TLB_INDEX), 64'd1);

        // Simultaneous misses: data first, inst follows after one idle cycle
        I_MISS = 1'b1; I_VPN = 22'h2A;
        walk(1'b1, 22'h11, 8'h07, 32'h0020_0000, 32'hABCD_E401, 0, 1'b0);
        walk(1'b0, 22'h2A, 8'h08, 32'h0030_0000, 32'h5555_5403, 1, 1'b0);

        // Flush mid-walk still completes
        walk(1'b0, 22'h3F_FFFF, 8'hC3, 32'h8000_0000, 32'h0000_0401, 1, 1'b1);

        // Address wrap modulo 2^32
        walk(1'b1, 22'h5, 8'h01, 32'hFFFF_FFF0, 32'h0000_1401, 0, 1'b0);
        check("wrap_addr", 64'(last_addr), 64'h0000_0004);

        // Reset mid-walk with a coincident ACK
        D_MISS = 1'b1; D_VPN = 22'h9; PT_BASE = 32'h0040_0000;
        @(negedge CLK);
        check("pre_rst_req", 64'(mem_bus.MEM_REQ), 64'd1);
        RESET = 1'b1;
        mem_bus.MEM_ACK = 1'b1; mem_bus.MEM_RDATA = 32'h0000_0C03;
        @(negedge CLK);
        check("rst_mid_req", 64'(mem_bus.MEM_REQ), 64'd0);
        check("rst_mid_busy", 64'(BUSY), 64'd0);
        check("rst_mid_we", 64'(TLB_WE), 64'd0);
        check("rst_mid_pulse", 64'(pulses), 64'd0);
        check("rst_mid_index", 64'(TLB_INDEX), 64'd0);
        model_ctr = 0;
        RESET = 1'b0; mem_bus.MEM_ACK = 1'b0; D_MISS = 1'b0;
        @(negedge CLK);
        check("post_rst_we", 64'(TLB_WE), 64'd0);
        check("post_rst_pulse", 64'(pulses), 64'd0);

        // Five refills: index 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            walk(k[0], 22'($urandom()), 8'($urandom()), $urandom(), ($urandom() | 32'd1), 0, 1'b0);
        end
        check("wrap_idx", 64'(TLB_INDEX), 64'd1);

        // Randomized walks
        for (int k = 0; k < 24; k++) begin
            pte_r = $urandom();
            pte_r[0] = ($urandom_range(3, 0) != 0);
            walk(1'($urandom()), 22'($urandom()), 8'($urandom()), $urandom(), pte_r,
                 $urandom_range(3, 0), 1'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
